// File: rtl/raw_pkg.sv
// rtl/raw_pkg.sv - shared constants and read-FSM state type for the raw hit buffer readout.
// RAW_READOUT_TRAILER_EN adds the TRAIL state.
package raw_pkg;

  localparam int RAW_ADDR_W          = 8;
  localparam int RAW_DATA_W          = 288;
  localparam int RAW_FRAME_W         = 16;
  localparam int RAW_FRAMES_PER_WORD = 18;
  localparam logic [7:0] RAW_TRAILER_ID = 8'hDE;

`ifdef RAW_READOUT_TRAILER_EN
  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_SETA  = 3'd1,
    RD_WAITD = 3'd2,
    RD_CAPT  = 3'd3,
    RD_SHIFT = 3'd4,
    RD_TRAIL = 3'd5,
    RD_REL   = 3'd6
  } raw_rd_state_t;
`else
  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_SETA  = 3'd1,
    RD_WAITD = 3'd2,
    RD_CAPT  = 3'd3,
    RD_SHIFT = 3'd4,
    RD_REL   = 3'd6
  } raw_rd_state_t;
`endif

endpackage

// File: rtl/raw_req_fifo.sv
// rtl/raw_req_fifo.sv - synchronous FIFO of pending block-start addresses.
module raw_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign rdata_o = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/raw_readout.sv
// rtl/raw_readout.sv - reads queued blocks from the raw hit buffer and ships them as 16-bit frames.
// RAW_READOUT_TRAILER_EN appends a {8'hDE, len} trailer frame to every block.
module raw_readout
  import raw_pkg::*;
#(
  parameter int ADDR_W    = RAW_ADDR_W,
  parameter int DATA_W    = RAW_DATA_W,
  parameter int FRAME_W   = RAW_FRAME_W,
  parameter int REQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  input  logic [7:0]         wblock,
  output logic [ADDR_W-1:0]  adr,
  input  logic [DATA_W-1:0]  dr,
  output logic [ADDR_W-1:0]  adb,
  output logic [FRAME_W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               busy
);

  localparam int FPW    = DATA_W / FRAME_W;
  localparam int FCNT_W = $clog2(FPW);
  localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(FPW - 1);

`ifdef RAW_READOUT_TRAILER_EN
  localparam raw_rd_state_t END_ST = RD_TRAIL;
`else
  localparam raw_rd_state_t END_ST = RD_REL;
`endif

  raw_rd_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [ADDR_W-1:0]  adb_q, adb_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [DATA_W-1:0]  sr_q, sr_d;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ADDR_W-1:0]  fifo_rdata;

  assign req_ready = !fifo_full;
  assign adr       = adr_q;
  assign adb       = adb_q;
  assign busy      = (state_q != RD_IDLE) || !fifo_empty;

  raw_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH (ADDR_W)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid && req_ready),
    .wdata_i (req_addr),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    adr_d    = adr_q;
    adb_d    = adb_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    fcnt_d   = fcnt_q;
    sr_d     = sr_q;
    fifo_pop = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          base_d   = fifo_rdata;
          len_d    = wblock;
          wcnt_d   = '0;
          if (wblock == 8'd0) begin
            state_d = END_ST;
          end else begin
            adr_d   = fifo_rdata;
            state_d = RD_SETA;
          end
        end
      end
      RD_SETA:  state_d = RD_WAITD;
      RD_WAITD: state_d = RD_CAPT;
      RD_CAPT: begin
        sr_d    = dr;
        fcnt_d  = '0;
        state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        if (dout_ready) begin
          sr_d   = sr_q >> FRAME_W;
          fcnt_d = fcnt_q + 1'b1;
          if (fcnt_q == LAST_FRAME) begin
            wcnt_d = wcnt_q + 8'd1;
            if (wcnt_q + 8'd1 == len_q) begin
              state_d = END_ST;
            end else begin
              adr_d   = adr_q + 1'b1;
              state_d = RD_SETA;
            end
          end
        end
      end
`ifdef RAW_READOUT_TRAILER_EN
      RD_TRAIL: begin
        if (dout_ready) state_d = RD_REL;
      end
`else
`endif
      RD_REL: begin
        // Releasing the block hands base..base+len-1 back to the writer.
        adb_d   = base_q + ADDR_W'(len_q);
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    case (state_q)
      RD_SHIFT: begin
        dout       = sr_q[FRAME_W-1:0];
        dout_valid = 1'b1;
`ifdef RAW_READOUT_TRAILER_EN
        dout_last  = 1'b0;
`else
        dout_last  = (fcnt_q == LAST_FRAME) && (wcnt_q + 8'd1 == len_q);
`endif
      end
`ifdef RAW_READOUT_TRAILER_EN
      RD_TRAIL: begin
        dout       = FRAME_W'({RAW_TRAILER_ID, len_q});
        dout_valid = 1'b1;
        dout_last  = 1'b1;
      end
`else
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      base_q  <= '0;
      adr_q   <= '0;
      adb_q   <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      adr_q   <= adr_d;
      adb_q   <= adb_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: tb/tb_raw_readout.sv
// tb/tb_raw_readout.sv - directed bench for raw_readout with a registered-read buffer model.
// Buffer word a holds frame k = {a, k}, so every expected frame is computable by hand.
module tb_raw_readout;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [7:0]   req_addr;
  logic         req_ready;
  logic [7:0]   wblock;
  logic [7:0]   adr;
  logic [287:0] dr;
  logic [7:0]   adb;
  logic [15:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         busy;

  logic [287:0] mem [256];
  int total = 0;
  int bad = 0;
  int first_cyc;
  int end_cyc;
  logic [7:0] adb_exp;

  raw_readout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .wblock     (wblock),
    .adr        (adr),
    .dr         (dr),
    .adb        (adb),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dr <= mem[adr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a);
    int g;
    g = 0;
    req_addr  = a;
    req_valid = 1'b1;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("push_timeout", 32'(g), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] b, input logic [7:0] l, input bit bp, input int stop_at);
    int n, idx, g, w, k;
    bit stalled;
    logic [15:0] hd, ef;
    logic hl, el;
    logic [7:0] wa;
    n = int'(l) * 18;
`ifdef RAW_READOUT_TRAILER_EN
    n = n + 1;
`endif
    idx = 0;
    g = 0;
    stalled = 1'b0;
    first_cyc = -1;
    while (idx < n && g < 5000) begin
      if (stop_at >= 0 && idx == stop_at && dout_valid) return;
      if (stalled) begin
        check("hold_valid", 32'(dout_valid), 32'd1);
        check("hold_data", 32'(dout), 32'(hd));
        check("hold_last", 32'(dout_last), 32'(hl));
      end
      dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (dout_valid) begin
        if (first_cyc < 0) first_cyc = g;
        w  = idx / 18;
        k  = idx % 18;
        wa = b + 8'(w);
        if (idx == int'(l) * 18) begin
          ef = {8'hDE, l};
          el = 1'b1;
        end else begin
          ef = {wa, 8'(k)};
`ifdef RAW_READOUT_TRAILER_EN
          el = 1'b0;
`else
          el = (w == int'(l) - 1) && (k == 17);
`endif
        end
        if (dout_ready) begin
          check("frame_data", 32'(dout), 32'(ef));
          check("frame_last", 32'(dout_last), 32'(el));
          if (k == 0 && idx < int'(l) * 18) check("word_adr", 32'(adr), 32'(wa));
          idx++;
        end else begin
          stalled = 1'b1;
          hd = dout;
          hl = dout_last;
        end
      end
      @(negedge clk);
      g++;
    end
    end_cyc = g;
    if (idx < n) check("drain_timeout", 32'(idx), 32'(n));
  endtask

  task automatic finish_block(input logic [7:0] new_adb);
    check("adb_early", 32'(adb), 32'(adb_exp));
    @(negedge clk);
    check("adb_release", 32'(adb), 32'(new_adb));
    adb_exp = new_adb;
  endtask

  initial begin
    int g;
    bit seen;
    logic [7:0] qlist [5];
    qlist[0] = 8'h80; qlist[1] = 8'h90; qlist[2] = 8'hA0; qlist[3] = 8'hB0; qlist[4] = 8'hC0;
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 18; k++)
        mem[a][16*k +: 16] = {8'(a), 8'(k)};
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = 8'h00;
    wblock = 8'd0;
    dout_ready = 1'b1;
    adb_exp = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_adb", 32'(adb), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word block with latency and throughput.
    wblock = 8'd2;
    push(8'h10);
    drain(8'h10, 8'd2, 1'b0, -1);
    check("basic_latency", 32'(first_cyc), 32'd4);
`ifdef RAW_READOUT_TRAILER_EN
    check("basic_cycles", 32'(end_cyc), 32'd44);
`else
    check("basic_cycles", 32'(end_cyc), 32'd43);
`endif
    finish_block(8'h12);
    check("idle_busy", 32'(busy), 32'd0);

    // Address wrap; wblock changed mid-block must be ignored.
    wblock = 8'd3;
    push(8'hFF);
    @(negedge clk);
    wblock = 8'd9;
    drain(8'hFF, 8'd3, 1'b0, -1);
    finish_block(8'h02);

    wblock = 8'd2;
    push(8'h40);
    drain(8'h40, 8'd2, 1'b1, -1);
    dout_ready = 1'b1;
    finish_block(8'h42);

    // Queue full while the first block is stalled.
    wblock = 8'd1;
    dout_ready = 1'b0;
    push(qlist[0]);
    g = 0;
    while (!dout_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("qf_stalled_valid", 32'(dout_valid), 32'd1);
    for (int i = 1; i < 5; i++) push(qlist[i]);
    check("qf_req_ready", 32'(req_ready), 32'd0);
    check("qf_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drain(qlist[i], 8'd1, 1'b0, -1);
      finish_block(qlist[i] + 8'd1);
    end

    wblock = 8'd0;
    push(8'h33);
`ifdef RAW_READOUT_TRAILER_EN
    drain(8'h33, 8'd0, 1'b0, -1);
    finish_block(8'h33);
`else
    g = 0;
    seen = 1'b0;
    while (adb !== 8'h33 && g < 50) begin
      if (dout_valid) seen = 1'b1;
      @(negedge clk);
      g++;
    end
    check("zero_adb", 32'(adb), 32'h33);
    check("zero_no_frames", 32'(seen), 32'd0);
    check("zero_cycles", 32'(g), 32'd2);
    adb_exp = 8'h33;
`endif

    // Reset at frame 5 of word 1 with a request still queued.
    wblock = 8'd3;
    push(8'h50);
    push(8'h60);
    drain(8'h50, 8'd3, 1'b0, 23);
    check("mid_frame", 32'(dout), 32'h5105);
    rst_n = 1'b0;
    #1;
    check("mid_rst_adr", 32'(adr), 32'd0);
    check("mid_rst_adb", 32'(adb), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_last", 32'(dout_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    adb_exp = 8'h00;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(dout_valid), 32'd0);
    wblock = 8'd1;
    push(8'h70);
    drain(8'h70, 8'd1, 1'b0, -1);
    finish_block(8'h71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/raw_readout.md
# raw_readout

Read-side controller for the 256 x 288-bit raw hit ring buffer. Accepts block-start addresses from trigger logic, reads each block word by word through the buffer's registered read port, and serializes every 288-bit word into 16-bit frames on a valid/ready stream to the DAQ link. When a block has been fully shipped, it advances the buffer's block pointer `adb`, releasing that space to the writer.

## Interface
- `ADDR_W`, 8, buffer address width; addressing wraps modulo 2^ADDR_W.
- `DATA_W`, 288, buffer word width.
- `FRAME_W`, 16, output frame width. DATA_W/FRAME_W = 18 frames per word.
- `REQ_DEPTH`, 4, request queue depth (power of 2).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a block request is presented.
- `req_addr` in ADDR_W: first buffer address of the requested block.
- `req_ready` out 1: the queue is not full. A request is accepted when `req_valid && req_ready`.
- `wblock` in 8: block length in words. Sampled when a request is popped from the queue.
- `adr` out ADDR_W: buffer read address, registered.
- `dr` in DATA_W: buffer read data. Valid one edge after `adr` is latched by the buffer.
- `adb` out ADDR_W: block release pointer, registered.
- `dout` out FRAME_W: output frame.
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: downstream accepts the frame.
- `dout_last` out 1: marks the final frame of a block.
- `busy` out 1: the FSM is not in IDLE, or the queue is non-empty.

## Operation
- **Request queue:** `raw_req_fifo` holds up to REQ_DEPTH addresses. `req_ready = !full`. A push into a full queue cannot occur. A pop happens only in IDLE.
- **FSM states:** IDLE, SETA, WAITD, CAPT, SHIFT, TRAIL (only with the macro), REL.
- **IDLE:**
  - If the queue is non-empty: pop it, latch `base = req_addr`, latch `len = wblock`, set `wcnt = 0`.
  - If `len == 0`: go to TRAIL when the macro is enabled, otherwise to REL.
  - Otherwise: `adr <= base`, go to SETA.
- **SETA → WAITD:** the buffer latches `adr`.
- **WAITD → CAPT:** `dr` becomes valid.
- **CAPT:** shift register `sr <= dr`, set `fcnt = 0`, go to SHIFT.
- **SHIFT:**
  - `dout = sr[FRAME_W-1:0]`, `dout_valid = 1`.
  - On `dout_ready`: shift `sr` right by FRAME_W and increment `fcnt`.
  - After frame 17 is accepted, increment `wcnt`.
  - If `wcnt == len`: go to TRAIL or REL. Otherwise `adr <= adr + 1` (wraps 255→0) and go to SETA.
- **TRAIL:** one frame `{8'hDE, len}`, with `dout_last = 1`. On accept, go to REL.
- **REL:** `adb <= base + len` (mod 256), go to IDLE. `adb` moves only here.
- **`dout_last`:** without the macro, asserted on frame 17 of word `len-1`.
- **Frame order:** LSB first. Frame k = word[16k+15:16k].

## Timing
- **Reset values:** `adr = 0`, `adb = 0`, `dout = 0`, `dout_valid = 0`, `dout_last = 0`, `busy = 0`, queue empty (so `req_ready = 1`).
- **Stream rules:** `dout` and `dout_last` are held stable while `dout_valid && !dout_ready`. `dout_valid` never drops without an accept.
- **Latency and throughput:**
  - Request accepted at edge N, FSM in IDLE → first frame valid after edge N+4 (pop, SETA, WAITD, CAPT).
  - Steady state: 18 + 3 cycles per word with `dout_ready` held high.
  - `adb` update lands 1 cycle after the last frame is accepted.
- **Simultaneous push and pop:** allowed in the same cycle.
- **Reset mid-block:** aborts the block. `adb` returns to 0 and pending requests are discarded. The write side is reset by the same `rst_n`.
- **`wblock` changes:** a change while a block is in progress has no effect on that block.

## Configuration
- `RAW_READOUT_TRAILER_EN`
  - **Defined:** the TRAIL state is present. Every block ends with trailer frame `{8'hDE, len}` carrying `dout_last`. A `len == 0` block emits only the trailer.
  - **Undefined:** no trailer. `dout_last` is on the last data frame. A `len == 0` block emits nothing and goes straight to REL, leaving `adb = base`.

## Structure
- **Shared package `raw_pkg`:**
  - constants `RAW_ADDR_W`, `RAW_DATA_W`, `RAW_FRAME_W`, `RAW_FRAMES_PER_WORD` = 18, `RAW_TRAILER_ID` = 8'hDE;
  - the FSM state enum `raw_rd_state_t`.
- **Sub-module `raw_req_fifo`:**
  - synchronous FIFO, REQ_DEPTH x ADDR_W;
  - outputs `full`/`empty`;
  - reset with `rst_n`.

## Test plan
- **Basic read:** `wblock = 2`, request `req_addr = 8'h10`, `dout_ready = 1`. Expect:
  - `adr` = 10 then 11;
  - 36 frames matching words mem[0x10] and mem[0x11], LSB first;
  - trailer `16'hDE02` with `dout_last` (macro on);
  - `adb = 8'h12`.
- **Wrap-around:** `req_addr = 8'hFF`, `wblock = 3`. Expect `adr` = FF, 00, 01 and `adb = 8'h02`.
- **Backpressure:** toggle `dout_ready` randomly on 50% of cycles. Expect no frame lost or duplicated, and `dout` stable while stalled.
- **Queue full:** push 4 requests while stalled. Expect `req_ready = 0`, then blocks served in FIFO order with `adb` advancing per block.
- **Zero length:** `wblock = 0`. Expect:
  - macro on: single frame `16'hDE00` with `dout_last`, `adb = base`;
  - macro off: no frames, `adb = base`.
- **Reset mid-block:** assert `rst_n = 0` at frame 5 of word 1. Expect all outputs at their reset values, the queue empty, and normal operation on the next request.
